// File: rtl/vec_mem_responder.sv
// Vector memory responder: splits 48-bit load/store requests into three 16-bit beats
// against a single-port synchronous RAM. Optional per-lane store mask via VEC_LANE_MASK_EN.
//
// state   | meaning
// IDLE    | waiting for a request (req_ready high once out of reset)
// WR      | issuing three lane writes, beat_q = 0..2
// RD      | issuing three lane reads, capturing lane beat_q-1 from mem_q
// RD_TAIL | capturing the last lane returned by the RAM
// RESP    | holding the response until rsp_ready

module vec_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int LANE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [3*LANE_W-1:0]   req_wdata,
`ifdef VEC_LANE_MASK_EN
    input  logic [2:0]            req_lmask,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [3*LANE_W-1:0]   rsp_data,
    output logic [ADDR_W+1:0]     mem_addr,
    output logic [LANE_W-1:0]     mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [LANE_W-1:0]     mem_q
);

    localparam int AW = ADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_TAIL = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [1:0]             beat_q;
    logic [3*LANE_W-1:0]    wdata_q;
    logic [2*LANE_W-1:0]    data_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [3*LANE_W-1:0]    rsp_data_q;
    logic [AW-1:0]          mem_addr_q;
    logic [LANE_W-1:0]      mem_wdata_q;
    logic                   mem_wren_q;
    logic                   mem_rden_q;
`ifdef VEC_LANE_MASK_EN
    logic [2:0]             lmask_q;
`endif

    // 3*A computed as (A<<1)+A in the widened address space, so A=255 reaches 767.
    logic [AW-1:0] base_addr;
    assign base_addr = ({2'b00, req_addr} << 1) + {2'b00, req_addr};

    function automatic logic [LANE_W-1:0] lane_sel(input logic [3*LANE_W-1:0] v,
                                                   input logic [1:0]          idx);
        case (idx)
            2'd0:    lane_sel = v[LANE_W-1:0];
            2'd1:    lane_sel = v[2*LANE_W-1:LANE_W];
            2'd2:    lane_sel = v[3*LANE_W-1:2*LANE_W];
            default: lane_sel = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
`ifdef VEC_LANE_MASK_EN
            lmask_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!req_ready_q) begin
                        req_ready_q <= 1'b1;
                    end else if (req_valid) begin
                        req_ready_q <= 1'b0;
                        wdata_q     <= req_wdata;
                        beat_q      <= 2'd0;
                        mem_addr_q  <= base_addr;
`ifdef VEC_LANE_MASK_EN
                        lmask_q     <= req_lmask;
`endif
                        if (req_we) begin
                            state_q     <= WR;
                            mem_wdata_q <= req_wdata[LANE_W-1:0];
`ifdef VEC_LANE_MASK_EN
                            mem_wren_q  <= req_lmask[0];
`else
                            mem_wren_q  <= 1'b1;
`endif
                        end else begin
                            state_q    <= RD;
                            mem_rden_q <= 1'b1;
                        end
                    end
                end

                WR: begin
                    if (beat_q == 2'd2) begin
                        state_q     <= RESP;
                        mem_wren_q  <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        beat_q      <= beat_q + 2'd1;
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= lane_sel(wdata_q, beat_q + 2'd1);
`ifdef VEC_LANE_MASK_EN
                        mem_wren_q  <= lmask_q[beat_q + 2'd1];
`else
                        mem_wren_q  <= 1'b1;
`endif
                    end
                end

                RD: begin
                    // RAM data lags the read strobe by one cycle, so beat b returns lane b-1.
                    if (beat_q == 2'd1) data_q[LANE_W-1:0]        <= mem_q;
                    if (beat_q == 2'd2) data_q[2*LANE_W-1:LANE_W] <= mem_q;
                    if (beat_q == 2'd2) begin
                        state_q    <= RD_TAIL;
                        mem_rden_q <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        beat_q     <= beat_q + 2'd1;
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                end

                RD_TAIL: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= {mem_q, data_q};
                end

                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign mem_rden  = mem_rden_q;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder with a 1-cycle-latency RAM model.
// Exercises the lane-mask store when built with VEC_LANE_MASK_EN.

module tb_vec_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [47:0] req_wdata;
`ifdef VEC_LANE_MASK_EN
    logic [2:0]  req_lmask;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [47:0] rsp_data;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wren;
    logic        mem_rden;
    logic [15:0] mem_q;

    logic [15:0] ram [0:1023];
    int n_pass  = 0;
    int n_total = 0;

    vec_mem_responder #(.ADDR_W(8), .LANE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef VEC_LANE_MASK_EN
        .req_lmask (req_lmask),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rden  (mem_rden),
        .mem_q     (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT idle; returns one step after the edge back to IDLE.
    task automatic do_store(input logic [7:0] a, input logic [47:0] d);
        logic [9:0] base;
        logic       exp_wren;
        base = {2'b00, a} * 10'd3;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_addr = ~a; req_wdata = ~d;
        chk("st_req_ready_drop", req_ready, 1'b0);
        for (int b = 0; b < 3; b++) begin
`ifdef VEC_LANE_MASK_EN
            exp_wren = req_lmask[b];
`else
            exp_wren = 1'b1;
`endif
            chk("st_wren", mem_wren, exp_wren);
            chk("st_rden", mem_rden, 1'b0);
            chk("st_addr", mem_addr, base + 10'(b));
            chk("st_wdata", mem_wdata, d[16*b +: 16]);
            chk("st_rsp_valid_early", rsp_valid, 1'b0);
            if (b < 2) tick();
        end
        tick();
        chk("st_rsp_valid", rsp_valid, 1'b1);
        chk("st_rsp_data", rsp_data, 48'h0);
        chk("st_wren_resp", mem_wren, 1'b0);
        chk("st_req_ready_resp", req_ready, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("st_rsp_done", rsp_valid, 1'b0);
        chk("st_req_ready_back", req_ready, 1'b1);
        for (int b = 0; b < 3; b++) begin
`ifdef VEC_LANE_MASK_EN
            if (req_lmask[b]) chk("st_ram", ram[base + 10'(b)], d[16*b +: 16]);
`else
            chk("st_ram", ram[base + 10'(b)], d[16*b +: 16]);
`endif
        end
    endtask

    // With hold set, returns one step after the edge that raised rsp_valid.
    task automatic do_load(input logic [7:0] a, input logic [47:0] exp, input bit hold);
        logic [9:0] base;
        base = {2'b00, a} * 10'd3;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 48'h0;
        tick();
        req_valid = 1'b0; req_we = 1'b1; req_addr = ~a; req_wdata = 48'hFFFF_FFFF_FFFF;
        for (int b = 0; b < 3; b++) begin
            chk("ld_rden", mem_rden, 1'b1);
            chk("ld_wren", mem_wren, 1'b0);
            chk("ld_addr", mem_addr, base + 10'(b));
            tick();
        end
        chk("ld_rden_tail", mem_rden, 1'b0);
        chk("ld_rsp_valid_early", rsp_valid, 1'b0);
        tick();
        chk("ld_rsp_valid", rsp_valid, 1'b1);
        chk("ld_rsp_data", rsp_data, exp);
        chk("ld_req_ready_resp", req_ready, 1'b0);
        if (!hold) begin
            rsp_ready = 1'b1;
            tick();
            chk("ld_rsp_done", rsp_valid, 1'b0);
            chk("ld_req_ready_back", req_ready, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0;
        mem_q = 16'h0;
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; req_wdata = 48'h0;
        rsp_ready = 1'b1;
`ifdef VEC_LANE_MASK_EN
        req_lmask = 3'b111;
`endif
        repeat (3) tick();
        chk("rst_ctrl", {req_ready, rsp_valid, mem_wren, mem_rden}, 4'b0000);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 26'h0);
        chk("rst_rsp_data", rsp_data, 48'h0);

        rst = 1'b1;
        tick();
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_no_accept", mem_rden, 1'b0);
        req_valid = 1'b0;

        do_store(8'd5, 48'h0123_4567_89AB);
        do_load(8'd5, 48'h0123_4567_89AB, 1'b0);

        rsp_ready = 1'b0;
        do_load(8'd5, 48'h0123_4567_89AB, 1'b1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd9; req_wdata = 48'h1111_2222_3333;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 48'h0123_4567_89AB);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_no_write", mem_wren, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", rsp_valid, 1'b0);
        chk("bp_release_ready", req_ready, 1'b1);

        do_store(8'd255, 48'hDEAD_BEEF_CAFE);
        do_load(8'd255, 48'hDEAD_BEEF_CAFE, 1'b0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_rd_beat1", {mem_rden, mem_addr}, {1'b1, 10'd16});
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {req_ready, rsp_valid, mem_wren, mem_rden}, 4'b0000);
        chk("mid_rst_addr_wdata", {mem_addr, mem_wdata}, 26'h0);
        chk("mid_rst_rsp_data", rsp_data, 48'h0);
        tick();
        chk("mid_rst_held", {req_ready, rsp_valid}, 2'b00);
        rst = 1'b1;
        tick();
        chk("mid_rel_req_ready", req_ready, 1'b1);
        chk("mid_rel_no_rsp", rsp_valid, 1'b0);
        do_load(8'd5, 48'h0123_4567_89AB, 1'b0);

`ifdef VEC_LANE_MASK_EN
        req_lmask = 3'b101;
        do_store(8'd5, 48'hFFFF_FFFF_FFFF);
        req_lmask = 3'b111;
        do_load(8'd5, 48'hFFFF_4567_FFFF, 1'b0);
        req_lmask = 3'b000;
        do_store(8'd5, 48'h0000_0000_0000);
        req_lmask = 3'b010;
        do_load(8'd5, 48'hFFFF_4567_FFFF, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the processor's 48-bit vector load/store path.
- Accepts one request at a time over a valid/ready handshake.
- Splits each request into three 16-bit lane beats against a narrow single-port synchronous backing RAM.
- Returns the reassembled 48-bit load data, or a store acknowledge, over a valid/ready response channel.

Parameters:
ADDR_W, 8, vector word address width; backing address width is ADDR_W+2.
LANE_W, 16, lane width; vector width is 3*LANE_W (48).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept (registered)
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  vector word address A
req_wdata  input  48  store data; lane i = bits [16i+15:16i]
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts response
rsp_data  output  48  load data; 0 for store acknowledge
mem_addr  output  ADDR_W+2  backing RAM address (registered)
mem_wdata  output  16  backing write lane (registered)
mem_wren  output  1  backing write enable (registered)
mem_rden  output  1  backing read enable (registered)
mem_q  input  16  backing read data, valid the cycle after mem_rden

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE; req_ready, rsp_valid, mem_wren and mem_rden are 0.
  - rsp_data, mem_addr and mem_wdata are 0.
  - Any in-flight transaction is abandoned. Lanes already written remain in RAM. No response is issued.
- req_ready rises on the first clk edge after rst deasserts. It is 1 only in IDLE.
- Acceptance occurs when req_valid and req_ready are both high at edge E0.
  - On the same edge the block latches req_we, req_addr and req_wdata, and req_ready drops.
- Address map: lane i of word A is at backing address 3*A+i, computed as (A<<1)+A+i in ADDR_W+2 bits. There is no wrap-around.
- States:
  - IDLE -> WR on an accepted store; IDLE -> RD on an accepted load.
  - WR: beat counter b = 0,1,2. In each cycle mem_wren=1, mem_addr=3A+b, mem_wdata = lane b. After b=2 -> RESP.
  - RD: b = 0,1,2. In each cycle mem_rden=1, mem_addr=3A+b. mem_q is captured into lane b-1 of the data register on each edge after the first. After b=2 -> RD_TAIL.
  - RD_TAIL: captures lane 2; mem_rden=0 -> RESP.
  - RESP: rsp_valid=1. rsp_data holds the assembled word for a load, or 0 for a store. On rsp_valid and rsp_ready -> IDLE, with req_ready=1 on that same edge.
- Latency, counted from acceptance edge E0:
  - Store: rsp_valid is visible after E3.
  - Load: rsp_valid is visible after E4.
  - Minimum request spacing is 5 cycles for a store and 6 for a load.
- Backpressure:
  - rsp_valid and rsp_data stay stable while rsp_ready=0, for any duration.
  - No new request is accepted while a response is pending.
- mem_wren and mem_rden are never high together. Both are 0 in IDLE and RESP.
- req_valid asserted during reset has no effect. The request is accepted only once req_ready=1.
- Changes on the req_* inputs after acceptance have no effect on the transaction in flight.

Optional Feature:
VEC_LANE_MASK_EN:
- Defined:
  - Adds input req_lmask [2:0], latched at acceptance.
  - In WR, beat b drives mem_wren = req_lmask[b]. Beat timing, mem_addr and latency are unchanged.
  - Loads ignore the mask.
  - A mask of 3'b000 still produces the store acknowledge.
- Undefined: the port is absent and all three lanes are always written.

Test Plan:
- Store, A=5, wdata 48'h0123_4567_89AB -> mem writes 89AB@15, 4567@16, 0123@17 in consecutive cycles; rsp_valid after E3 with rsp_data=0.
- Load A=5 after the store above, model RAM with 1-cycle read -> rsp_data=48'h0123_4567_89AB, rsp_valid after E4; mem_rden high for exactly 3 cycles.
- Load with rsp_ready held low 4 cycles -> rsp_valid and rsp_data constant, req_ready=0 throughout; IDLE reached on the edge where rsp_ready=1.
- Boundary A=255 (ADDR_W=8) -> mem_addr 765, 766, 767; no truncation; data round-trips.
- Pull rst low in RD at b=1 -> all outputs 0 immediately; no rsp_valid; after release req_ready=1 next edge and a new load of A=5 returns the correct data.
- VEC_LANE_MASK_EN, lmask=3'b101, store 48'hFFFF_FFFF_FFFF over prior 0123_4567_89AB -> readback 48'hFFFF_4567_FFFF.
